// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the LEGv8 immediate-generation stage.
// Opcode values are matched against the leading instruction bits of each format.
package imm_gen_pkg;

    typedef enum logic [3:0] {
        FMT_NONE = 4'd0,
        FMT_D    = 4'd1,
        FMT_CB   = 4'd2,
        FMT_B    = 4'd3,
        FMT_IA   = 4'd4,
        FMT_IL   = 4'd5,
        FMT_IW   = 4'd6,
        FMT_SH   = 4'd7
    } imm_fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    // a[31:21]
    localparam logic [10:0] OP_LDUR  = 11'h7C2;
    localparam logic [10:0] OP_STUR  = 11'h7C0;
    localparam logic [10:0] OP_LSL   = 11'h69B;
    localparam logic [10:0] OP_LSR   = 11'h69A;
    // a[31:24]
    localparam logic [7:0]  OP_CBZ   = 8'hB4;
    localparam logic [7:0]  OP_CBNZ  = 8'hB5;
    // a[31:26]
    localparam logic [5:0]  OP_B     = 6'h05;
    localparam logic [5:0]  OP_BL    = 6'h25;
    // a[31:22]
    localparam logic [9:0]  OP_ADDI  = 10'h244;
    localparam logic [9:0]  OP_SUBI  = 10'h344;
    localparam logic [9:0]  OP_ADDIS = 10'h2C4;
    localparam logic [9:0]  OP_SUBIS = 10'h3C4;
    localparam logic [9:0]  OP_ANDI  = 10'h248;
    localparam logic [9:0]  OP_ORRI  = 10'h2C8;
    localparam logic [9:0]  OP_EORI  = 10'h348;
    // a[31:23]
    localparam logic [8:0]  OP_MOVZ  = 9'h1A5;
    localparam logic [8:0]  OP_MOVK  = 9'h1E5;

    localparam int D_W  = 9;
    localparam int CB_W = 19;
    localparam int B_W  = 26;
    localparam int I_W  = 12;
    localparam int IW_W = 16;
    localparam int SH_W = 6;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational LEGv8 immediate extractor: picks the first matching format
// and sign- or zero-extends its field to N bits.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [31:0]  instr,
    output logic [N-1:0] imm,
    output imm_fmt_t     fmt
);

    logic [63:0] iw_val;
    logic        unused_low;

    assign unused_low = ^instr[4:0];

    always_comb begin
        imm    = '0;
        fmt    = FMT_NONE;
        // hw selects a 16-bit lane; the result never reaches above bit 63
        iw_val = {48'b0, instr[20:5]} << {instr[22:21], 4'b0000};

        if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
            imm = {{(N-D_W){instr[20]}}, instr[20:12]};
            fmt = FMT_D;
        end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
            imm = {{(N-CB_W-2){instr[23]}}, instr[23:5], 2'b00};
            fmt = FMT_CB;
        end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
            imm = {{(N-B_W-2){instr[25]}}, instr[25:0], 2'b00};
            fmt = FMT_B;
        end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI ||
                     instr[31:22] == OP_ADDIS || instr[31:22] == OP_SUBIS) begin
            imm = {{(N-I_W){instr[21]}}, instr[21:10]};
            fmt = FMT_IA;
        end else if (instr[31:22] == OP_ANDI || instr[31:22] == OP_ORRI ||
                     instr[31:22] == OP_EORI) begin
            imm = {{(N-I_W){1'b0}}, instr[21:10]};
            fmt = FMT_IL;
        end else if (instr[31:23] == OP_MOVZ || instr[31:23] == OP_MOVK) begin
            imm[63:0] = iw_val;
            fmt       = FMT_IW;
        end else if (instr[31:21] == OP_LSL || instr[31:21] == OP_LSR) begin
            imm = {{(N-SH_W){1'b0}}, instr[15:10]};
            fmt = FMT_SH;
        end
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: valid/ready handshake with a
// 2-entry skid buffer and synchronous flush around the imm_decode block.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int N     = 64,
    parameter int TAG_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     imm,
    output logic [3:0]       fmt,
    output logic [TAG_W-1:0] out_tag
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; valid and its payload stay stable until that edge.
    stage_state_t     state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [N-1:0]     main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    imm_fmt_t         main_fmt_q, main_fmt_d, skid_fmt_q, skid_fmt_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
    logic [N-1:0]     dec_imm;
    imm_fmt_t         dec_fmt;
    logic             acc, pop;

    imm_decode #(.N(N)) u_decode (
        .instr (instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign imm       = main_imm_q;
    assign fmt       = main_fmt_q;
    assign out_tag   = main_tag_q;
    assign acc       = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_fmt_d = main_fmt_q;
        main_tag_d = main_tag_q;
        skid_imm_d = skid_imm_q;
        skid_fmt_d = skid_fmt_q;
        skid_tag_d = skid_tag_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_imm_d = dec_imm;
                        main_fmt_d = dec_fmt;
                        main_tag_d = in_tag;
                        state_d    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && pop) begin
                        main_imm_d = dec_imm;
                        main_fmt_d = dec_fmt;
                        main_tag_d = in_tag;
                    end else if (acc) begin
                        skid_imm_d = dec_imm;
                        skid_fmt_d = dec_fmt;
                        skid_tag_d = in_tag;
                        state_d    = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        main_imm_d = skid_imm_q;
                        main_fmt_d = skid_fmt_q;
                        main_tag_d = skid_tag_q;
                        state_d    = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // ready is registered, so it is derived from where we are going
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_imm_q <= '0;
            main_fmt_q <= FMT_NONE;
            main_tag_q <= '0;
            skid_imm_q <= '0;
            skid_fmt_q <= FMT_NONE;
            skid_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_imm_q <= main_imm_d;
            main_fmt_q <= main_fmt_d;
            main_tag_q <= main_tag_d;
            skid_imm_q <= skid_imm_d;
            skid_fmt_q <= skid_fmt_d;
            skid_tag_q <= skid_tag_d;
        end
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, parametrised immediate-generation stage for the LEGv8 datapath. It decodes every immediate-bearing format: D, CB, B, I (arithmetic and logical), IW (MOVZ/MOVK) and shift-amount. It extends the immediate to N bits and emits it with a format code. It sits between fetch/decode and register read, behind a valid/ready handshake with a 2-entry skid buffer, and supports pipeline flush.

Parameters:
N, 64, output immediate width; legal N >= 64; extension continues to bit N-1
TAG_W, 64, width of sideband tag (normally PC) carried alongside the instruction

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous pipeline flush; discards all held and incoming entries
in_valid  in  1  instr/in_tag valid
in_ready  out  1  stage can accept; registered, equals !skid_valid
instr  in  32  raw instruction word
in_tag  in  TAG_W  sideband passed through unchanged
out_valid  out  1  imm/fmt/out_tag valid
out_ready  in  1  downstream accepts
imm  out  N  extended immediate
fmt  out  4  imm_fmt_t code of decoded format
out_tag  out  TAG_W  tag of the entry on the output

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset).
- Reset: out_valid=0, in_ready=1, imm=0, fmt=FMT_NONE, out_tag=0, skid cleared.
- Decode is combinational. First match wins, in this order:
  1. LDUR 0x7C2 / STUR 0x7C0 (a[31:21]) -> sext(a[20:12]), FMT_D.
  2. CBZ 0xB4 / CBNZ 0xB5 (a[31:24]) -> sext({a[23:5],2'b0}), FMT_CB.
  3. B 0x05 / BL 0x25 (a[31:26]) -> sext({a[25:0],2'b0}), FMT_B.
  4. ADDI 0x244 / SUBI 0x344 / ADDIS 0x2C4 / SUBIS 0x3C4 (a[31:22]) -> sext(a[21:10]), FMT_IA.
  5. ANDI 0x248 / ORRI 0x2C8 / EORI 0x348 (a[31:22]) -> zext(a[21:10]), FMT_IL.
  6. MOVZ 0x1A5 / MOVK 0x1E5 (a[31:23]) -> zext(a[20:5]) << (16*a[22:21]), FMT_IW.
  7. LSL 0x69B / LSR 0x69A (a[31:21]) -> zext(a[15:10]), FMT_SH.
  8. Anything else -> imm=0, FMT_NONE. No error flag.
- Latency: 1 cycle from accepted input to out_valid with an empty stage. Throughput is 1/cycle while out_ready=1.
- Storage: main register (drives outputs) and skid register.
- States:
  - EMPTY (main invalid)
  - ONE (main valid, skid invalid)
  - TWO (both valid)
- Transitions, with acc = in_valid & in_ready and pop = out_valid & out_ready:
  - EMPTY: acc -> ONE (main <= decode).
  - ONE: acc & pop -> ONE (main <= decode). acc & !pop -> TWO (skid <= decode). pop & !acc -> EMPTY.
  - TWO: in_ready=0. pop -> ONE (main <= skid). Otherwise hold.
- Output stability: outputs hold stable while out_valid=1 and out_ready=0.
- Flush: next state EMPTY, the same-cycle acc is dropped, and in_ready=1 next cycle. Flush takes priority over acc/pop. Data registers may keep stale values, but out_valid=0.
- Reset mid-operation: all entries lost immediately (asynchronous). First accept allowed on the first clk edge after deassertion.
- Sign extension: always from the field MSB after the <<2 concatenation. MOVZ with hw=3 places imm16 at bits 63:48; bits above 63 are 0 when N>64.

Decomposition:
- Package imm_gen_pkg:
  - imm_fmt_t enum [3:0]: FMT_NONE=0, FMT_D, FMT_CB, FMT_B, FMT_IA, FMT_IL, FMT_IW, FMT_SH.
  - Opcode localparams for all opcodes above.
  - Field-width constants (9, 19, 26, 12, 16, 6).
- Sub-module imm_decode (combinational, parameter N): instr -> imm, fmt. It is the drop-in generalisation of the existing extender.
- imm_gen_stage holds the handshake, skid buffer and flush logic only.

Test Plan:
- Formats, each with out_ready=1 and one in_valid pulse; each result appears one cycle later:
  - LDUR 0xF85F8000 -> imm=0xFFFFFFFFFFFFFFF8, fmt=FMT_D.
  - CBZ 0xB4FFFFE0 -> imm=0xFFFFFFFFFFFFFFFC, fmt=FMT_CB.
  - B 0x16000000 -> imm=0xFFFFFFFFF8000000, fmt=FMT_B.
  - ADDI 0x91200000 -> 0xFFFFFFFFFFFFF800, FMT_IA.
  - ORRI 0xB2200000 -> 0x0000000000000800, FMT_IL.
  - MOVZ 0xD2D579A0 -> 0x0000ABCD00000000, FMT_IW.
  - 0x00000000 -> imm=0, FMT_NONE.
- Backpressure: stream 4 instructions with tags 0..3 and out_ready=0 -> in_ready falls after the 2nd accept and out_tag holds 0. Raise out_ready -> tags 0,1,2,3 drain in order with no loss or duplication.
- Flush in TWO state with in_valid=1 -> next cycle out_valid=0 and in_ready=1, and the flushed-cycle input never appears.
- Async reset asserted between clk edges while out_valid=1 -> out_valid=0 and fmt=FMT_NONE before the next edge.
- N=96: B 0x16000000 -> imm[95:0]=0xFFFFFFFF_FFFFFFFF_F8000000. MOVZ hw=3 imm16=0x1234 (0xD2E24680) -> 0x00000000_12340000_00000000.
